// File: rtl/alu_seq_sliced_pkg.sv
// rtl/alu_seq_sliced_pkg.sv - command/state encodings and helpers for the slice-serial ALU
package alu_seq_sliced_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Commands that go through the adder and report carry/overflow.
    function automatic logic is_arith(alu_cmd_e cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB) || (cmd == ALU_SLT);
    endfunction

    // Commands that subtract: B is inverted and carry-in starts at 1.
    function automatic logic inverts_b(alu_cmd_e cmd);
        return (cmd == ALU_SUB) || (cmd == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_seq_sliced_slice.sv
// rtl/alu_seq_sliced_slice.sv - combinational SLICE_W-bit ALU slice with ripple carry in/out
module alu_seq_sliced_slice
    import alu_seq_sliced_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_eff,
    input  logic               cin,
    input  alu_cmd_e           cmd,
    output logic [SLICE_W-1:0] res,
    output logic               cout,
    output logic               msb_sum
);

    logic [SLICE_W:0] sum;

    always_comb begin
        sum     = (SLICE_W+1)'(a) + (SLICE_W+1)'(b_eff) + (SLICE_W+1)'(cin);
        msb_sum = sum[SLICE_W-1];
        res     = sum[SLICE_W-1:0];
        cout    = 1'b0;
        case (cmd)
            ALU_ADD, ALU_SUB, ALU_SLT: begin
                res  = sum[SLICE_W-1:0];
                cout = sum[SLICE_W];
            end
            ALU_XOR:  res = a ^ b_eff;
            ALU_AND:  res = a & b_eff;
            ALU_NAND: res = ~(a & b_eff);
            ALU_NOR:  res = ~(a | b_eff);
            ALU_OR:   res = a | b_eff;
            default:  res = sum[SLICE_W-1:0];
        endcase
    end

endmodule

// File: rtl/alu_seq_sliced.sv
// rtl/alu_seq_sliced.sv - multi-cycle ALU processing SLICE_W bits per clock, LSB slice first
module alu_seq_sliced
    import alu_seq_sliced_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [2:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int OFF_W  = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (WIDTH < 2 || (WIDTH % SLICE_W) != 0) begin : g_param_check
        $error("alu_seq_sliced: WIDTH must be >= 2 and a multiple of SLICE_W");
    end

    state_e             state;
    alu_cmd_e           cmd_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [OFF_W-1:0]   off;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_res;
    logic               s_cout;
    logic               s_msb;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   final_res;
    logic               ovf_arith;
    alu_cmd_e           cmd_in;

    assign cmd_in   = alu_cmd_e'(command);
    assign in_ready = (state == S_IDLE) && rst_n;

    alu_seq_sliced_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a       (a_sl),
        .b_eff   (b_sl),
        .cin     (carry),
        .cmd     (cmd_reg),
        .res     (s_res),
        .cout    (s_cout),
        .msb_sum (s_msb)
    );

    // Partial results build up in acc; result only updates on DONE entry.
    always_comb begin
        off      = OFF_W'(idx * SLICE_W);
        a_sl     = a_reg[off +: SLICE_W];
        b_sl     = b_reg[off +: SLICE_W];
        acc_next = acc;
        acc_next[off +: SLICE_W] = s_res;
        ovf_arith = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s_msb != a_reg[WIDTH-1]);
        final_res = acc_next;
        if (cmd_reg == ALU_SLT) begin
            final_res    = '0;
            final_res[0] = s_msb ^ ovf_arith;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_reg   <= ALU_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= operandA;
                        b_reg   <= inverts_b(cmd_in) ? ~operandB : operandB;
                        cmd_reg <= cmd_in;
                        carry   <= inverts_b(cmd_in);
                        acc     <= '0;
                        idx     <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_next;
                    carry <= s_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= final_res;
                        carryout  <= is_arith(cmd_reg) ? s_cout : 1'b0;
                        overflow  <= is_arith(cmd_reg) ? ovf_arith : 1'b0;
                        zero      <= (final_res == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_sliced.sv
// tb/tb_alu_seq_sliced.sv - checks three slice widths (8, 1, 32) against an arithmetic reference model
module tb_alu_seq_sliced;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [2:0]  command;

    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [2:0][31:0] res;
    logic [2:0]       co;
    logic [2:0]       zr;
    logic [2:0]       of;

    int checks   = 0;
    int failures = 0;

    int          lat [3];
    logic [31:0] got_res [3];
    logic [2:0]  got_co, got_zr, got_of;

    always #5 clk = ~clk;

    alu_seq_sliced #(.WIDTH(32), .SLICE_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .operandA(operandA), .operandB(operandB), .command(command),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
        .carryout(co[0]), .zero(zr[0]), .overflow(of[0]));

    alu_seq_sliced #(.WIDTH(32), .SLICE_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .operandA(operandA), .operandB(operandB), .command(command),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
        .carryout(co[1]), .zero(zr[1]), .overflow(of[1]));

    alu_seq_sliced #(.WIDTH(32), .SLICE_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .operandA(operandA), .operandB(operandB), .command(command),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
        .carryout(co[2]), .zero(zr[2]), .overflow(of[2]));

    function automatic int nslice(int i);
        return (i == 0) ? 4 : (i == 1) ? 32 : 1;
    endfunction

    // Returns {overflow, zero, carryout, result}.
    function automatic logic [34:0] ref_alu(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, v;
        s = '0; cy = 1'b0; v = 1'b0;
        case (c)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                v  = (a[31] == b[31]) && (s[31] != a[31]);
            end
            3'd1, 3'd3: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                cy = s[32];
                v  = (a[31] != b[31]) && (s[31] != a[31]);
                r  = (c == 3'd1) ? s[31:0] : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            end
            3'd2: r = a ^ b;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {v, (r == 32'd0), cy, r};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        logic [34:0] e;
        logic [2:0]  seen;
        e = ref_alu(c, a, b);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("in_ready_pre[%0d]", i), 32'(ir[i]), 32'd1);
        in_valid  = 1'b1;
        command   = c;
        operandA  = a;
        operandB  = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
        command  = 3'($urandom);
        seen = '0;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int cyc = 1; cyc <= 40 && seen != 3'b111; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i]    = 1'b1;
                    lat[i]     = cyc;
                    got_res[i] = res[i];
                    got_co[i]  = co[i];
                    got_zr[i]  = zr[i];
                    got_of[i]  = of[i];
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d] cmd%0d", i, c), 32'(lat[i]), 32'(nslice(i)));
            chk($sformatf("result[%0d] cmd%0d %h,%h", i, c, a, b), got_res[i], e[31:0]);
            chk($sformatf("carryout[%0d] cmd%0d", i, c), 32'(got_co[i]), 32'(e[32]));
            chk($sformatf("zero[%0d] cmd%0d", i, c), 32'(got_zr[i]), 32'(e[33]));
            chk($sformatf("overflow[%0d] cmd%0d", i, c), 32'(got_of[i]), 32'(e[34]));
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [34:0] e;
        int          vcount;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operandA = '0; operandB = '0; command = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd0);
            chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_result[%0d]", i), res[i], 32'd0);
            chk($sformatf("rst_flags[%0d]", i), {29'd0, co[i], zr[i], of[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("post_rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);

        // Directed vectors, with fixed expectations on the 8-bit-slice instance as well.
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001);
        chk("add_wrap_result", got_res[0], 32'h0);
        chk("add_wrap_flags", {29'd0, got_co[0], got_zr[0], got_of[0]}, 32'b110);
        run_op(3'd1, 32'h80000000, 32'h00000001);
        chk("sub_ovf_result", got_res[0], 32'h7FFFFFFF);
        chk("sub_ovf_flags", {29'd0, got_co[0], got_zr[0], got_of[0]}, 32'b101);
        run_op(3'd3, 32'hFFFFFFFF, 32'h00000001);
        chk("slt_neg_result", got_res[0], 32'h1);
        run_op(3'd3, 32'h7FFFFFFF, 32'h80000000);
        chk("slt_ovf_result", got_res[0], 32'h0);
        run_op(3'd2, 32'hA5A5A5A5, 32'hFFFF0000);
        chk("xor_result", got_res[0], 32'h5A5AA5A5);
        chk("xor_flags", {29'd0, got_co[0], got_zr[0], got_of[0]}, 32'b000);
        run_op(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("nand_result", got_res[0], 32'h0);
        chk("nand_zero", 32'(got_zr[0]), 32'd1);
        run_op(3'd4, 32'h0F0F00FF, 32'h00FF0F0F);
        run_op(3'd6, 32'h12345678, 32'h00000000);
        run_op(3'd7, 32'h80000001, 32'h00010000);
        run_op(3'd1, 32'h00000005, 32'h00000005);

        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (n % 4 == 0) ? ra : $urandom;
            run_op(3'($urandom_range(0, 7)), ra, rb);
        end

        // Consumer stall: result held, in_ready low, in_valid pulses ignored.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; command = 3'd0;
        operandA  = 32'h12345678; operandB = 32'h11111111;
        e = ref_alu(3'd0, 32'h12345678, 32'h11111111);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vcount = 0;
        for (int cyc = 1; cyc <= 10 && !ov[0]; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            vcount = cyc;
        end
        chk("stall_latency", 32'(vcount), 32'd4);
        held = res[0];
        chk("stall_result", held, e[31:0]);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            operandA = $urandom; operandB = $urandom; command = 3'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall_hold_result_%0d", k), res[0], held);
            chk($sformatf("stall_out_valid_%0d", k), 32'(ov[0]), 32'd1);
            chk($sformatf("stall_in_ready_%0d", k), 32'(ir[0]), 32'd0);
            chk($sformatf("stall_flags_%0d", k), {29'd0, co[0], zr[0], of[0]},
                {29'd0, e[32], e[33], e[34]});
            chk($sformatf("stall_in_ready32_%0d", k), 32'(ir[2]), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(ov[0]), 32'd0);
        chk("release_in_ready", 32'(ir[0]), 32'd1);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[0] || ov[2]) vcount++;
        end
        chk("no_spurious_after_stall", 32'(vcount), 32'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("drain_in_ready[%0d]", i), 32'(ir[i]), 32'd1);

        // Reset during BUSY cycle 2 drops the operation.
        in_valid = 1'b1; command = 3'd0;
        operandA = 32'h00000001; operandB = 32'h00000002;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_in_ready_low[%0d]", i), 32'(ir[i]), 32'd0);
            chk($sformatf("midrst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            chk($sformatf("midrst_result[%0d]", i), res[i], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
            chk($sformatf("midrst_out_valid_after[%0d]", i), 32'(ov[i]), 32'd0);
        end
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov != 3'b000) vcount++;
        end
        chk("midrst_no_result", 32'(vcount), 32'd0);

        run_op(3'd1, 32'h00000000, 32'h00000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
